// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparison datapath between the branch-resolve
// port (0) and the trap/set-compare port (1), each with a 1-entry response buffer.
module cmp_arbiter #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  input  logic [OP_W-1:0]  req_op0,
  input  logic [OP_W-1:0]  req_op1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic             rsp_result0,
  output logic             rsp_result1,
  output logic [TAG_W-1:0] rsp_tag0,
  output logic [TAG_W-1:0] rsp_tag1,
  output logic [1:0]       rsp_badop
);

  localparam logic [OP_W-1:0] CMP_EQ  = OP_W'(0);
  localparam logic [OP_W-1:0] CMP_NE  = OP_W'(1);
  localparam logic [OP_W-1:0] CMP_LT  = OP_W'(2);
  localparam logic [OP_W-1:0] CMP_LE  = OP_W'(3);
  localparam logic [OP_W-1:0] CMP_GT  = OP_W'(4);
  localparam logic [OP_W-1:0] CMP_GE  = OP_W'(5);
  localparam logic [OP_W-1:0] CMP_NEW = OP_W'(6);

  // Returns {badop, result}; unsupported codes yield result 0.
  function automatic logic [1:0] cmp_eval(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input logic [OP_W-1:0]    op);
    logic [1:0] r;
    case (op)
      CMP_EQ:  r = {1'b0, a == b};
      CMP_NE:  r = {1'b0, a != b};
      CMP_LT:  r = {1'b0, a <  b};
      CMP_LE:  r = {1'b0, a <= b};
      CMP_GT:  r = {1'b0, a >  b};
      CMP_GE:  r = {1'b0, a >= b};
      CMP_NEW: r = 2'b10;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  logic             prio_q, prio_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       result_q, result_d;
  logic [1:0]       badop_q, badop_d;
  logic [TAG_W-1:0] tag0_q, tag0_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [31:0]      sel_a, sel_b;
  logic [OP_W-1:0]  sel_op;
  logic [1:0]       cmp_out;

  always_comb begin
    // A full buffer being drained this cycle can accept a new request.
    elig = req_valid & (~rsp_valid_q | rsp_ready);
    if (&elig) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end

    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end

    sel_a   = grant[1] ? req_a1  : req_a0;
    sel_b   = grant[1] ? req_b1  : req_b0;
    sel_op  = grant[1] ? req_op1 : req_op0;
    cmp_out = cmp_eval(sel_a, sel_b, sel_op);

    rsp_valid_d = grant | (rsp_valid_q & ~rsp_ready);
    result_d    = result_q;
    badop_d     = badop_q;
    tag0_d      = tag0_q;
    tag1_d      = tag1_q;
    if (grant[0]) begin
      result_d[0] = cmp_out[0];
      badop_d[0]  = cmp_out[1];
      tag0_d      = req_tag0;
    end
    if (grant[1]) begin
      result_d[1] = cmp_out[0];
      badop_d[1]  = cmp_out[1];
      tag1_d      = req_tag1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      result_q    <= 2'b00;
      badop_q     <= 2'b00;
      tag0_q      <= '0;
      tag1_q      <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      badop_q     <= badop_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result0 = result_q[0];
  assign rsp_result1 = result_q[1];
  assign rsp_tag0    = tag0_q;
  assign rsp_tag1    = tag1_q;
  assign rsp_badop   = badop_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: vector table plus hand-written arbitration sequences,
// responses checked through per-port scoreboard queues.
module tb_cmp_arbiter;

  localparam logic [4:0] OP_EQ  = 5'd0;
  localparam logic [4:0] OP_NE  = 5'd1;
  localparam logic [4:0] OP_LT  = 5'd2;
  localparam logic [4:0] OP_LE  = 5'd3;
  localparam logic [4:0] OP_GT  = 5'd4;
  localparam logic [4:0] OP_GE  = 5'd5;
  localparam logic [4:0] OP_NEW = 5'd6;

  typedef struct packed {
    logic       res;
    logic [3:0] tag;
    logic       badop;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [3:0]  tag;
    logic        res;
    logic        badop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];
  logic [4:0]  op_in [2];
  logic [3:0]  tag_in [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic        res0, res1;
  logic [3:0]  tag0, tag1;
  logic [1:0]  rsp_badop;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur_exp [2];
  bit   pend [2];
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vt [14];

  always #5 clk = ~clk;

  cmp_arbiter #(.TAG_W(4), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(a_in[0]), .req_b0(b_in[0]), .req_a1(a_in[1]), .req_b1(b_in[1]),
    .req_op0(op_in[0]), .req_op1(op_in[1]),
    .req_tag0(tag_in[0]), .req_tag1(tag_in[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result0(res0), .rsp_result1(res1),
    .rsp_tag0(tag0), .rsp_tag1(tag1),
    .rsp_badop(rsp_badop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t dut_rsp(input int i);
    exp_t r;
    if (i == 0) r = '{res: res0, tag: tag0, badop: rsp_badop[0]};
    else        r = '{res: res1, tag: tag1, badop: rsp_badop[1]};
    return r;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [3:0] tag,
                         input logic res, input logic badop);
    req_valid[p] = 1'b1;
    a_in[p]      = a;
    b_in[p]      = b;
    op_in[p]     = op;
    tag_in[p]    = tag;
    cur_exp[p]   = '{res: res, tag: tag, badop: badop};
  endtask

  // Called at a negedge with inputs already set; evaluates the handshakes that
  // the next rising edge will perform, then advances to the following negedge.
  task automatic tick(input logic [1:0] exp_rdy, input bit chk_rdy);
    exp_t h;
    int   qs;
    #1;
    if (chk_rdy) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        chk($sformatf("rsp%0d_latency", i), 32'(rsp_valid[i]), 32'd1);
        pend[i] = 1'b0;
      end
      if (rsp_valid[i]) begin
        qs = (i == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          chk($sformatf("rsp%0d_unexpected", i), 32'(rsp_valid[i]), 32'd0);
        end else begin
          h = (i == 0) ? q0[0] : q1[0];
          chk($sformatf("rsp%0d_{res,tag,badop}", i), 32'(dut_rsp(i)), 32'(h));
          if (rsp_ready[i]) begin
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
      if (req_valid[i] && req_ready[i]) begin
        if (i == 0) q0.push_back(cur_exp[0]);
        else        q1.push_back(cur_exp[1]);
        pend[i] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n     = 1'b0;
    #2;
    q0.delete();
    q1.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{0, 32'hFFFF_FFFF, 32'd1,        OP_LT,  4'h1, 1'b1, 1'b0};
    vt[1]  = '{0, 32'd5,         32'd5,        OP_GE,  4'h2, 1'b1, 1'b0};
    vt[2]  = '{0, 32'd7,         32'd7,        OP_NE,  4'h3, 1'b0, 1'b0};
    vt[3]  = '{1, 32'd0,         32'd0,        OP_NEW, 4'h4, 1'b0, 1'b1};
    vt[4]  = '{1, 32'd0,         32'd0,        5'h1F,  4'h5, 1'b0, 1'b1};
    vt[5]  = '{1, 32'd0,         32'd0,        OP_EQ,  4'h6, 1'b1, 1'b0};
    vt[6]  = '{0, 32'h7FFF_FFFF, 32'h8000_0000, OP_LE, 4'h7, 1'b0, 1'b0};
    vt[7]  = '{1, 32'h8000_0000, 32'h7FFF_FFFF, OP_LT, 4'h8, 1'b1, 1'b0};
    vt[8]  = '{0, 32'd0,         32'hFFFF_FFFF, OP_GE, 4'h9, 1'b1, 1'b0};
    vt[9]  = '{1, 32'h8000_0000, 32'd0,        OP_GT,  4'hA, 1'b0, 1'b0};
    vt[10] = '{0, 32'd3,         32'd3,        OP_EQ,  4'hB, 1'b1, 1'b0};
    vt[11] = '{1, 32'd5,         32'd5,        OP_LE,  4'hC, 1'b1, 1'b0};
    vt[12] = '{0, 32'd1,         32'd2,        OP_NE,  4'hD, 1'b1, 1'b0};
    vt[13] = '{1, 32'd2,         32'd1,        OP_GT,  4'hE, 1'b1, 1'b0};

    for (int i = 0; i < 2; i++) begin
      a_in[i] = '0; b_in[i] = '0; op_in[i] = '0; tag_in[i] = '0;
      cur_exp[i] = '0; pend[i] = 1'b0;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result0", 32'(res0), 32'd0);
    chk("reset_result1", 32'(res1), 32'd0);
    chk("reset_tag0", 32'(tag0), 32'd0);
    chk("reset_tag1", 32'(tag1), 32'd0);
    chk("reset_badop", 32'(rsp_badop), 32'd0);
    @(negedge clk);

    // Mid-transaction asynchronous reset discards a buffered response
    set_req(0, 32'd1, 32'd1, OP_EQ, 4'h9, 1'b1, 1'b0);
    tick(2'b01, 1'b1);
    req_valid = 2'b00;
    tick(2'b00, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_tag0", 32'(tag0), 32'd0);
    chk("async_reset_result0", 32'(res0), 32'd0);
    q0.delete(); q1.delete(); pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, 32'd2, 32'd2, OP_EQ, 4'h1, 1'b1, 1'b0);
    set_req(1, 32'd3, 32'd4, OP_EQ, 4'h2, 1'b0, 1'b0);
    tick(2'b01, 1'b1);
    req_valid[0] = 1'b0;
    tick(2'b10, 1'b1);
    req_valid = 2'b00;
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    // Table of single-port requests, issued back to back
    reset_dut();
    rsp_ready = 2'b11;
    for (int k = 0; k < 14; k++) begin
      req_valid = 2'b00;
      set_req(vt[k].port, vt[k].a, vt[k].b, vt[k].op, vt[k].tag, vt[k].res, vt[k].badop);
      tick((vt[k].port == 1) ? 2'b10 : 2'b01, 1'b1);
    end
    req_valid = 2'b00;
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    // Both ports continuously requesting: grants alternate starting at port 0
    reset_dut();
    rsp_ready = 2'b11;
    set_req(0, 32'd3, 32'd3, OP_EQ, 4'h2, 1'b1, 1'b0);
    set_req(1, 32'h8000_0000, 32'd0, OP_GT, 4'h1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick((k % 2 == 1) ? 2'b10 : 2'b01, 1'b1);
    req_valid = 2'b00;
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    // Port 1 consumer stalled with a full buffer; port 0 streams through
    reset_dut();
    rsp_ready = 2'b01;
    set_req(1, 32'd1, 32'd0, OP_GT, 4'h5, 1'b1, 1'b0);
    tick(2'b10, 1'b1);
    set_req(1, 32'd9, 32'd9, OP_EQ, 4'h6, 1'b1, 1'b0);
    set_req(0, 32'd1, 32'd2, OP_LT, 4'h7, 1'b1, 1'b0);
    repeat (4) tick(2'b01, 1'b1);
    rsp_ready = 2'b11;
    tick(2'b10, 1'b1);
    req_valid[1] = 1'b0;
    tick(2'b01, 1'b1);
    req_valid = 2'b00;
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);

    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one signed/unsigned-equality comparison datapath between two requesters: port 0 is the branch-resolve path and port 1 is the trap/set-compare path.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Each port has a 1-entry response buffer, so a stalled consumer on one port never blocks the other port.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- OP_W, 5, width of the comparison opcode; the encodings are the `CMP_* macros in Defines.v.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accepted this cycle.
- req_a0, req_b0, req_a1, req_b1  in  32  operands for port 0 and port 1.
- req_op0, req_op1  in  OP_W  comparison opcode for each port.
- req_tag0, req_tag1  in  TAG_W  request tag for each port.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response consumer ready.
- rsp_result0, rsp_result1  out  1  comparison result.
- rsp_tag0, rsp_tag1  out  TAG_W  tag echoed from the accepted request.
- rsp_badop  out  2  per-port flag: the opcode was not a supported comparison.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_badop=0.
  - Priority pointer prio=0, meaning port 0 has priority.
  - Reset mid-transaction discards any buffered response; no response is emitted after reset for requests accepted before reset.
- Eligibility: port i is eligible when req_valid[i]=1 AND (rsp_valid[i]=0 OR rsp_ready[i]=1). The second term lets a drain and a new accept happen in the same cycle.
- Grant:
  - At most one port is granted per cycle.
  - If both ports are eligible, grant goes to port prio.
  - If one port is eligible, it is granted regardless of prio.
  - req_ready[i]=grant[i]. This is combinational from req_valid, rsp_valid and rsp_ready; it never depends on operand or opcode values.
- prio update: on a grant to port i, prio <= ~i. With no grant, prio holds.
- Comparison (a single shared datapath; its inputs are muxed by grant):
  - `CMP_EQ → A==B; `CMP_NE → A!=B.
  - `CMP_LT / `CMP_LE / `CMP_GT / `CMP_GE → two's-complement signed comparison.
  - `CMP_NEW and any other code → result 0 with badop=1. badop=0 for the six supported codes.
- Latency:
  - A request accepted in cycle N gives rsp_valid[i]=1 in cycle N+1, with the registered result, tag and badop.
  - There is no combinational path from req_* to rsp_*.
- Response hold:
  - While rsp_valid[i]=1 and rsp_ready[i]=0, rsp_result[i], rsp_tag[i] and rsp_badop[i] are stable.
  - On rsp_ready[i]=1 with no new accept, rsp_valid[i] <= 0.
  - On rsp_ready[i]=1 with a new accept in the same cycle, the buffer is overwritten and rsp_valid stays 1.
- Requester rule: req_a, req_b, req_op and req_tag stay stable while req_valid=1 and req_ready=0. The block does not latch requests that were not accepted.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1…; neither port waits more than 1 cycle for a grant.
- Full buffer: port i with a full buffer and rsp_ready[i]=0 is ineligible. The other port may be granted every cycle, and prio still updates only on actual grants.
- Throughput: 1 accept per cycle in aggregate; each port is limited to 1 accept per cycle when its consumer is always ready.

Test Plan:
- Reset with rsp_valid held high from a prior accept, deassert rst_n mid-cycle → rsp_valid=00 immediately; after release, first simultaneous request grants port 0.
- Port 0 only, back-to-back, rsp_ready0=1:
  - Requests LT(0xFFFFFFFF,1), GE(5,5), NE(7,7), one per cycle.
  - Expect req_ready0=1 each cycle.
  - Next-cycle results are 1, 1, 0 with matching tags.
- Both ports valid continuously, both consumers ready → grants alternate 0,1,0,1. Check a sample compare on each port:
  - Port 1 GT(0x80000000,0) → 0.
  - Port 0 EQ(3,3) → 1.
- Port 1 consumer stalled (rsp_ready1=0) with a response buffered, both ports requesting:
  - Port 1 is never granted and rsp_tag1/rsp_result1 stay constant.
  - Port 0 is granted every cycle.
  - Raise rsp_ready1: that cycle both drains port 1 and accepts its new request (if prio permits); next cycle shows the new tag.
- Opcode `CMP_NEW, then an undefined code (e.g. 5'h1F), A=B=0 → result 0, badop=1 for both; a following EQ(0,0) gives badop=0, result 1.
- Signed boundaries:
  - LE(0x7FFFFFFF,0x80000000) → 0.
  - LT(0x80000000,0x7FFFFFFF) → 1.
  - GE(0,0xFFFFFFFF) → 1.
